// File: rtl/oclib_pkg.sv
// Shared CSR types and arbiter constants for the oclib CSR fabric.
package oclib_pkg;

  // Request from a CSR master toward a CSR target.
  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  space;
  } csr_32_s;

  // Feedback from a CSR target back to the master.
  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
    logic        error;
  } csr_32_fb_s;

  // Arbiter FSM: IDLE scans, GRANT owns the target, RELEASE forces a gap.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } csr_arb_state_e;

  // Read data returned to a master whose transaction was retired by timeout.
  localparam logic [31:0] CsrArbTimeoutData = 32'hDEAD_0001;

endpackage

// File: rtl/oclib_rr_arbiter.sv
// Combinational round-robin picker: scans from pointer+1 (mod Requesters)
// and returns the first requester as a one-hot winner.
module oclib_rr_arbiter #(
  parameter int Requesters = 2,
  parameter int PtrW       = (Requesters > 1) ? $clog2(Requesters) : 1
) (
  input  logic [Requesters-1:0] request,
  input  logic [PtrW-1:0]       pointer,
  output logic [Requesters-1:0] winner,
  output logic                  valid
);

  // Walk the candidates in priority order; the first hit locks out the rest.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = 1; k <= Requesters; k++) begin
      for (int i = 0; i < Requesters; i++) begin
        if (!valid && (i == ((int'(pointer) + k) % Requesters)) && request[i]) begin
          winner[i] = 1'b1;
          valid     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/oclib_csr_arbiter.sv
// Round-robin arbiter sharing one CSR target between several CSR masters.
// Handshake: a master holds read/write and the rest of its request stable
// until it sees inFb.ready=1 (with rdata/error valid in that same cycle),
// and drops read/write in the following cycle. The target likewise sees a
// stable request on out until it raises outFb.ready.
// A hung target is retired after TimeoutCycles grant cycles with an error.
module oclib_csr_arbiter
  import oclib_pkg::*;
#(
  parameter type CsrType       = oclib_pkg::csr_32_s,
  parameter type CsrFbType     = oclib_pkg::csr_32_fb_s,
  parameter int  Requesters    = 2,
  parameter int  TimeoutCycles = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  CsrType                in    [Requesters],
  output CsrFbType              inFb  [Requesters],
  output CsrType                out,
  input  CsrFbType              outFb,
  output logic [Requesters-1:0] grant,
  output logic                  timeoutPulse,
  output csr_arb_state_e        debug_state
);

  localparam int PtrW   = (Requesters > 1) ? $clog2(Requesters) : 1;
  localparam int TimerW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [TimerW-1:0] TimeoutLast =
    TimerW'((TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0);
  localparam logic TimeoutEn = (TimeoutCycles != 0);

  csr_arb_state_e        state_q, state_d;
  logic [Requesters-1:0] grant_q, grant_d;
  logic [PtrW-1:0]       gidx_q, gidx_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [TimerW-1:0]     timer_q, timer_d;

  logic [Requesters-1:0] request;
  logic [Requesters-1:0] winner;
  logic                  winner_valid;
  logic [PtrW-1:0]       winner_idx;

  // Collapse each master's request into a single "wants the target" bit.
  always_comb begin
    request = '0;
    for (int i = 0; i < Requesters; i++) begin
      request[i] = in[i].read | in[i].write;
    end
  end

  oclib_rr_arbiter #(
    .Requesters (Requesters),
    .PtrW       (PtrW)
  ) u_rr (
    .request (request),
    .pointer (ptr_q),
    .winner  (winner),
    .valid   (winner_valid)
  );

  // Encode the one-hot winner so the muxes can index by number.
  always_comb begin
    winner_idx = '0;
    for (int i = 0; i < Requesters; i++) begin
      if (winner[i]) begin
        winner_idx = PtrW'(i);
      end
    end
  end

  // State, grant, pointer and timer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic and the request/feedback muxes. Requests toward the
  // target are gated by state, so an async reset drops them immediately.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    ptr_d        = ptr_q;
    timer_d      = timer_q;
    out          = '0;
    timeoutPulse = 1'b0;
    for (int i = 0; i < Requesters; i++) begin
      inFb[i] = '0;
    end

    case (state_q)
      IDLE: begin
        if (winner_valid) begin
          state_d = GRANT;
          grant_d = winner;
          gidx_d  = winner_idx;
          timer_d = '0;
        end
      end

      GRANT: begin
        out          = in[gidx_q];
        inFb[gidx_q] = outFb;
        if (outFb.ready) begin
          // Target completion wins over a coincident timeout.
          ptr_d   = gidx_q;
          state_d = RELEASE;
        end else if (TimeoutEn && (timer_q == TimeoutLast)) begin
          inFb[gidx_q].ready = 1'b1;
          inFb[gidx_q].error = 1'b1;
          inFb[gidx_q].rdata = CsrArbTimeoutData;
          timeoutPulse       = 1'b1;
          state_d            = RELEASE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end

      RELEASE: begin
        // One dead cycle so the target always sees read/write drop.
        grant_d = '0;
        state_d = IDLE;
      end

      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign grant       = grant_q;
  assign debug_state = state_q;

endmodule

// File: tb/tb_oclib_csr_arbiter.sv
// Directed and randomized checks of the CSR round-robin arbiter.
module tb_oclib_csr_arbiter;
  import oclib_pkg::*;

  localparam int NR         = 3;
  localparam int T          = 8;
  localparam int RandCycles = 600;
  localparam csr_32_fb_s TmoFb = '{rdata: 32'hDEAD_0001, ready: 1'b1, error: 1'b1};

  // Clock and reset.
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  csr_32_s        in    [NR];
  csr_32_fb_s     inFb  [NR];
  csr_32_s        out;
  csr_32_fb_s     outFb;
  logic [NR-1:0]  grant;
  logic           timeoutPulse;
  csr_arb_state_e debug_state;

  oclib_csr_arbiter #(
    .CsrType       (csr_32_s),
    .CsrFbType     (csr_32_fb_s),
    .Requesters    (NR),
    .TimeoutCycles (T)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in           (in),
    .inFb         (inFb),
    .out          (out),
    .outFb        (outFb),
    .grant        (grant),
    .timeoutPulse (timeoutPulse),
    .debug_state  (debug_state)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard comparison.
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NR; i++) in[i] = '0;
    outFb = '0;
  endtask

  // Reference model state for the randomized phase.
  int         owner, gstart, gdone, lat, ptr_m;
  bit         pend [NR];
  bit         drop [NR];
  csr_32_s    mreq [NR];
  bit         busy, rel, tmo;
  logic [NR-1:0] exp_grant;
  csr_32_fb_s exp_fb;
  csr_32_s    exp_out;
  int         exp_w [4];

  initial begin
    clear_inputs();
    // Reset state.
    #1 reset = 1'b0;
    #2;
    chk("rst_grant", grant, '0);
    chk("rst_tmo", timeoutPulse, 1'b0);
    chk("rst_out_rw", {out.read, out.write}, 2'b00);
    for (int i = 0; i < NR; i++) chk($sformatf("rst_infb%0d", i), inFb[i], '0);
    chk("rst_state", debug_state, IDLE);
    @(negedge clock); reset = 1'b1;

    // Single master 0 write, target ready on the 4th grant cycle.
    @(negedge clock);
    in[0] = '{read: 1'b0, write: 1'b1, address: 32'h10, wdata: 32'hA5, space: 4'h0};
    #1;
    chk("t1_idle_write", out.write, 1'b0);
    @(negedge clock); #1;
    chk("t1_out_write", out.write, 1'b1);
    chk("t1_out_addr", out.address, 32'h10);
    chk("t1_out_wdata", out.wdata, 32'hA5);
    chk("t1_grant", grant, 3'b001);
    chk("t1_wait_ready", inFb[0].ready, 1'b0);
    repeat (2) begin
      @(negedge clock); #1;
      chk("t1_wait_ready", inFb[0].ready, 1'b0);
    end
    @(negedge clock); outFb.ready = 1'b1; outFb.rdata = 32'h1234; #1;
    chk("t1_ready", inFb[0].ready, 1'b1);
    chk("t1_rdata", inFb[0].rdata, 32'h1234);
    chk("t1_error", inFb[0].error, 1'b0);
    @(negedge clock); clear_inputs(); #1;
    chk("t1_rel_write", out.write, 1'b0);
    chk("t1_rel_grant", grant, 3'b001);
    chk("t1_rel_infb", inFb[0], '0);
    @(negedge clock); #1;
    chk("t1_grant_off", grant, 3'b000);

    // Masters 0 and 1 both keep requesting: grants alternate 1,0,1,0.
    exp_w = '{1, 0, 1, 0};
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        in[i] = '{read: 1'b1, write: 1'b0, address: 32'(i * 4), wdata: 32'h0, space: 4'h1};
      end
      #1;
      chk("t2_idle_grant", grant, 3'b000);
      @(negedge clock); outFb.ready = 1'b1; outFb.rdata = 32'(k); #1;
      chk("t2_grant", grant, (exp_w[k] == 1) ? 3'b010 : 3'b001);
      for (int i = 0; i < 2; i++) begin
        if (i == exp_w[k]) chk("t2_ready", inFb[i].ready, 1'b1);
      end
      @(negedge clock); outFb.ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (i == exp_w[k]) in[i] = '0;
      end
      #1;
      chk("t2_rel_read", out.read, 1'b0);
    end
    @(negedge clock); clear_inputs(); #1;

    // Target never answers: master 2 is retired on its 8th grant cycle.
    @(negedge clock);
    in[2] = '{read: 1'b1, write: 1'b0, address: 32'h20, wdata: 32'h0, space: 4'h2};
    outFb.rdata = 32'h77;
    #1;
    for (int j = 1; j <= T; j++) begin
      @(negedge clock); #1;
      chk("t3_grant", grant, 3'b100);
      if (j < T) begin
        chk("t3_early_ready", inFb[2].ready, 1'b0);
        chk("t3_early_tmo", timeoutPulse, 1'b0);
      end else begin
        chk("t3_tmo_fb", inFb[2], TmoFb);
        chk("t3_tmo_pulse", timeoutPulse, 1'b1);
      end
    end
    @(negedge clock); clear_inputs(); #1;
    chk("t3_pulse_once", timeoutPulse, 1'b0);
    chk("t3_rel_ready", inFb[2].ready, 1'b0);
    chk("t3_rel_read", out.read, 1'b0);
    @(negedge clock); #1;
    chk("t3_grant_off", grant, 3'b000);

    // Target ready coincides with the timeout: target wins.
    @(negedge clock);
    in[1] = '{read: 1'b0, write: 1'b1, address: 32'h44, wdata: 32'h99, space: 4'h3};
    #1;
    for (int j = 1; j <= T; j++) begin
      @(negedge clock);
      if (j == T) begin outFb.ready = 1'b1; outFb.rdata = 32'h5A5A; end
      #1;
      if (j == T) begin
        chk("t4_ready", inFb[1].ready, 1'b1);
        chk("t4_error", inFb[1].error, 1'b0);
        chk("t4_rdata", inFb[1].rdata, 32'h5A5A);
        chk("t4_no_pulse", timeoutPulse, 1'b0);
      end
    end
    @(negedge clock); clear_inputs(); #1;
    chk("t4_rel_pulse", timeoutPulse, 1'b0);
    @(negedge clock); #1;
    chk("t4_grant_off", grant, 3'b000);

    // Async reset during a grant (pointer is 1 beforehand).
    @(negedge clock);
    in[2] = '{read: 1'b0, write: 1'b1, address: 32'h88, wdata: 32'h1, space: 4'h0};
    #1;
    @(negedge clock); #1;
    chk("t6_grant", grant, 3'b100);
    chk("t6_write", out.write, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_write", out.write, 1'b0);
    chk("t6_rst_grant", grant, 3'b000);
    chk("t6_rst_state", debug_state, IDLE);
    @(negedge clock); clear_inputs(); reset = 1'b1; #1;
    @(negedge clock);
    in[0] = '{read: 1'b1, write: 1'b0, address: 32'h0, wdata: 32'h0, space: 4'h0};
    in[1] = '{read: 1'b1, write: 1'b0, address: 32'h4, wdata: 32'h0, space: 4'h0};
    #1;
    @(negedge clock); outFb.ready = 1'b1; #1;
    chk("t6_ptr_restart", grant, 3'b010);
    chk("t6_ready", inFb[1].ready, 1'b1);
    @(negedge clock); clear_inputs(); #1;
    @(negedge clock); #1;
    chk("t6_grant_off", grant, 3'b000);

    // Back-to-back reads from master 0: read must drop between them.
    @(negedge clock);
    in[0] = '{read: 1'b1, write: 1'b0, address: 32'h30, wdata: 32'h0, space: 4'h0};
    #1;
    @(negedge clock); outFb.ready = 1'b1; #1;
    chk("t5_first_read", out.read, 1'b1);
    @(negedge clock); clear_inputs(); #1;
    chk("t5_gap_rel", out.read, 1'b0);
    @(negedge clock);
    in[0] = '{read: 1'b1, write: 1'b0, address: 32'h34, wdata: 32'h0, space: 4'h0};
    #1;
    chk("t5_gap_idle", out.read, 1'b0);
    @(negedge clock); outFb.ready = 1'b1; #1;
    chk("t5_second_read", out.read, 1'b1);
    chk("t5_second_grant", grant, 3'b001);
    @(negedge clock); clear_inputs(); #1;

    // Randomized traffic against a transaction-level model.
    owner = -1; ptr_m = 0; gdone = -1; gstart = 0; lat = 0;
    for (int i = 0; i < NR; i++) begin pend[i] = 1'b0; drop[i] = 1'b0; end
    for (int cyc = 0; cyc < RandCycles; cyc++) begin
      @(negedge clock);
      for (int i = 0; i < NR; i++) begin
        if (drop[i]) begin
          pend[i] = 1'b0;
          drop[i] = 1'b0;
        end else if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i]          = 1'b1;
          mreq[i].read     = 1'($urandom_range(0, 1));
          mreq[i].write    = ~mreq[i].read;
          mreq[i].address  = $urandom;
          mreq[i].wdata    = $urandom;
          mreq[i].space    = 4'($urandom_range(0, 15));
        end
        in[i] = pend[i] ? mreq[i] : '0;
      end
      busy = (owner >= 0) && (gdone < 0) && (cyc >= gstart);
      rel  = (owner >= 0) && (gdone >= 0) && (cyc == gdone + 1);
      outFb.rdata = $urandom;
      outFb.error = 1'($urandom_range(0, 1));
      outFb.ready = busy ? (cyc == gstart + lat) : ($urandom_range(0, 3) == 0);
      #1;
      tmo = busy && !outFb.ready && (cyc == gstart + T - 1);
      exp_grant = '0;
      exp_out   = '0;
      for (int i = 0; i < NR; i++) begin
        exp_fb = '0;
        if ((busy || rel) && (i == owner)) exp_grant[i] = 1'b1;
        if (busy && (i == owner)) begin
          exp_fb  = tmo ? TmoFb : outFb;
          exp_out = in[i];
        end
        chk($sformatf("rnd_infb%0d", i), inFb[i], exp_fb);
      end
      if (busy) chk("rnd_out", out, exp_out);
      else      chk("rnd_out_rw_idle", {out.read, out.write}, 2'b00);
      chk("rnd_grant", grant, exp_grant);
      chk("rnd_tmo", timeoutPulse, tmo);

      if (busy && (outFb.ready || tmo)) begin
        gdone = cyc;
        for (int i = 0; i < NR; i++) if (i == owner) drop[i] = 1'b1;
        if (outFb.ready) ptr_m = owner;
      end else if (rel) begin
        owner = -1;
      end else if (owner < 0) begin
        for (int k = 1; k <= NR; k++) begin
          for (int i = 0; i < NR; i++) begin
            if ((owner < 0) && (i == (ptr_m + k) % NR) && pend[i]) owner = i;
          end
        end
        if (owner >= 0) begin
          gstart = cyc + 1;
          gdone  = -1;
          lat    = $urandom_range(0, T + 1);
        end
      end
    end

    // Final report.
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
